// File: rtl/sysctrl_ext.sv
// sysctrl_ext: memory-mapped system control block.
// Holds clock/trap/IRQ routing selects, and monitors power-good inputs
// through 2-flop synchronizers. A falling synchronized power-good level
// latches a sticky event bit (write-1-to-clear); enabled events raise pwr_irq.
// Bus accesses complete with a single-cycle ready pulse and registered rdata.
module sysctrl_ext #(
    parameter logic [31:0] BASE_ADR = 32'h2300_0000,
    parameter int          NUM_PWR  = 4,
    parameter int          NUM_CLK  = 2,
    parameter int          NUM_IRQ  = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [31:0]        iomem_addr,
    input  logic               iomem_valid,
    input  logic [3:0]         iomem_wstrb,
    input  logic [31:0]        iomem_wdata,
    output logic [31:0]        iomem_rdata,
    output logic               iomem_ready,
    input  logic [NUM_PWR-1:0] pwrgood_in,
    output logic [NUM_CLK-1:0] clk_output_dest,
    output logic               trap_output_dest,
    output logic [NUM_IRQ-1:0] irq_inputsrc,
    output logic               pwr_irq
);

    localparam logic [7:0] OFS_PWR_STATUS = 8'h00;
    localparam logic [7:0] OFS_CLK_OUT    = 8'h04;
    localparam logic [7:0] OFS_TRAP_OUT   = 8'h08;
    localparam logic [7:0] OFS_IRQ_SRC    = 8'h0C;
    localparam logic [7:0] OFS_PWR_EVENT  = 8'h10;
    localparam logic [7:0] OFS_PWR_IRQ_EN = 8'h14;

    logic [NUM_PWR-1:0] pwr_s1_q, pwr_s2_q;
    logic [NUM_PWR-1:0] pwr_event_q, pwr_event_d;
    logic [NUM_PWR-1:0] pwr_irq_en_q, pwr_irq_en_d;
    logic [NUM_CLK-1:0] clk_dest_q, clk_dest_d;
    logic               trap_dest_q, trap_dest_d;
    logic [NUM_IRQ-1:0] irq_src_q, irq_src_d;
    logic               pwr_irq_q, pwr_irq_d;
    logic               ready_q, ready_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               hit;
    logic               wr;
    logic [7:0]         ofs;
    logic [31:0]        bmask;
    logic [31:0]        wdat_m;
    logic [31:0]        rd_word;
    logic [NUM_PWR-1:0] pwr_fall;
    logic [NUM_PWR-1:0] pwr_clr;
    logic               unused_wdat;

    assign ofs    = iomem_addr[7:0];
    assign hit    = iomem_valid && !ready_q && (iomem_addr[31:8] == BASE_ADR[31:8]);
    assign wr     = hit && (iomem_wstrb != 4'b0000);
    assign bmask  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                     {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign wdat_m = iomem_wdata & bmask;
    assign unused_wdat = ^wdat_m;

    // Read mux: fields are zero-extended, unmapped offsets read as zero.
    always_comb begin
        rd_word = '0;
        case (ofs)
            OFS_PWR_STATUS: rd_word[NUM_PWR-1:0] = pwr_s2_q;
            OFS_CLK_OUT:    rd_word[NUM_CLK-1:0] = clk_dest_q;
            OFS_TRAP_OUT:   rd_word[0]           = trap_dest_q;
            OFS_IRQ_SRC:    rd_word[NUM_IRQ-1:0] = irq_src_q;
            OFS_PWR_EVENT:  rd_word[NUM_PWR-1:0] = pwr_event_q;
            OFS_PWR_IRQ_EN: rd_word[NUM_PWR-1:0] = pwr_irq_en_q;
            default:        rd_word = '0;
        endcase
    end

    // Next-state for registers, event tracking and bus handshake.
    always_comb begin
        clk_dest_d   = clk_dest_q;
        trap_dest_d  = trap_dest_q;
        irq_src_d    = irq_src_q;
        pwr_irq_en_d = pwr_irq_en_q;
        pwr_clr      = '0;

        if (wr) begin
            case (ofs)
                OFS_CLK_OUT:
                    clk_dest_d = (clk_dest_q & ~bmask[NUM_CLK-1:0]) | wdat_m[NUM_CLK-1:0];
                OFS_TRAP_OUT:
                    trap_dest_d = bmask[0] ? iomem_wdata[0] : trap_dest_q;
                OFS_IRQ_SRC:
                    irq_src_d = (irq_src_q & ~bmask[NUM_IRQ-1:0]) | wdat_m[NUM_IRQ-1:0];
                OFS_PWR_EVENT:
                    pwr_clr = wdat_m[NUM_PWR-1:0];
                OFS_PWR_IRQ_EN:
                    pwr_irq_en_d = (pwr_irq_en_q & ~bmask[NUM_PWR-1:0]) | wdat_m[NUM_PWR-1:0];
                default: ;
            endcase
        end

        // s1 holds the value s2 takes on this edge, so s2 & ~s1 marks a 1->0 step.
        // Applying the set after the clear makes a coincident fall win.
        pwr_fall    = pwr_s2_q & ~pwr_s1_q;
        pwr_event_d = (pwr_event_q & ~pwr_clr) | pwr_fall;

        pwr_irq_d = |(pwr_event_q & pwr_irq_en_q);
        ready_d   = hit;
        rdata_d   = hit ? rd_word : rdata_q;
    end

    // State registers, including the power-good synchronizer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwr_s1_q     <= '0;
            pwr_s2_q     <= '0;
            pwr_event_q  <= '0;
            pwr_irq_en_q <= '0;
            clk_dest_q   <= '0;
            trap_dest_q  <= 1'b0;
            irq_src_q    <= '0;
            pwr_irq_q    <= 1'b0;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            pwr_s1_q     <= pwrgood_in;
            pwr_s2_q     <= pwr_s1_q;
            pwr_event_q  <= pwr_event_d;
            pwr_irq_en_q <= pwr_irq_en_d;
            clk_dest_q   <= clk_dest_d;
            trap_dest_q  <= trap_dest_d;
            irq_src_q    <= irq_src_d;
            pwr_irq_q    <= pwr_irq_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
        end
    end

    assign iomem_rdata      = rdata_q;
    assign iomem_ready      = ready_q;
    assign clk_output_dest  = clk_dest_q;
    assign trap_output_dest = trap_dest_q;
    assign irq_inputsrc     = irq_src_q;
    assign pwr_irq          = pwr_irq_q;

endmodule

// File: doc/sysctrl_ext.md
SYSCTRL_EXT -- requirements
Module: sysctrl_ext

Interface
REQ-001 Parameter BASE_ADR, default 32'h2300_0000: register block base; only bits [31:8] are decoded.
REQ-002 Parameter NUM_PWR, default 4, legal range 1..32: number of power-good monitor inputs.
REQ-003 Parameter NUM_CLK, default 2, legal range 1..32: number of clock-output destination selects.
REQ-004 Parameter NUM_IRQ, default 2, legal range 1..32: number of IRQ input-source selects.
REQ-005 Port clk, input, 1: the block's only clock; all state changes on its rising edge.
REQ-006 Port resetn, input, 1: asynchronous, active-low reset.
REQ-007 Port iomem_addr, input, 32: byte address.
REQ-008 Port iomem_valid, input, 1: access request.
REQ-009 Port iomem_wstrb, input, 4: byte write strobes; all zero means read.
REQ-010 Port iomem_wdata, input, 32: write data.
REQ-011 Port iomem_rdata, output, 32: read data, registered.
REQ-012 Port iomem_ready, output, 1: access completion pulse.
REQ-013 Port pwrgood_in, input, NUM_PWR: asynchronous power-good levels.
REQ-014 Port clk_output_dest, output, NUM_CLK: clock destination selects.
REQ-015 Port trap_output_dest, output, 1: trap destination select.
REQ-016 Port irq_inputsrc, output, NUM_IRQ: IRQ source selects.
REQ-017 Port pwr_irq, output, 1: power-fail interrupt, level, registered.

Function
REQ-018 Register map (offset = iomem_addr[7:0]):
- 0x00 PWR_STATUS: RO, synchronized pwrgood.
- 0x04 CLK_OUT: RW.
- 0x08 TRAP_OUT: RW, bit 0.
- 0x0C IRQ_SRC: RW.
- 0x10 PWR_EVENT: RW1C.
- 0x14 PWR_IRQ_EN: RW.
REQ-019 Every register field occupies bits [N-1:0] of its word; bits above N read 0 and ignore writes.
REQ-020 A hit is iomem_valid=1, iomem_ready=0 and iomem_addr[31:8]==BASE_ADR[31:8].
REQ-021 On a hit, the block drives iomem_ready=1 for exactly one cycle on the next edge and loads iomem_rdata on that same edge.
REQ-022 Accesses are single-cycle latency; there are no back-to-back ready pulses.
REQ-023 A hit to any unmapped offset returns iomem_rdata=0, gets ready, and has no side effect.
REQ-024 An access whose address misses BASE_ADR never gets ready, and iomem_rdata holds its previous value.
REQ-025 Write masking: field bit i is written only if iomem_wstrb[i/8]=1.
REQ-026 Read data returned with a write is the pre-write register value.
REQ-027 Each pwrgood_in bit passes through a 2-flop synchronizer (s1 then s2); s2 is PWR_STATUS.
REQ-028 PWR_EVENT bit i sets on the edge where s2[i] changes 1->0, and stays set until cleared.
REQ-029 Writing 1 (under strobe) to a PWR_EVENT bit clears it; writing 0 has no effect.
REQ-030 If a set and a clear of the same PWR_EVENT bit occur on the same edge, the set wins.
REQ-031 pwr_irq is registered and equals |(PWR_EVENT & PWR_IRQ_EN), one cycle after the operand values.
REQ-032 A rising edge of s2 has no effect on PWR_EVENT.

Reset
REQ-033 When resetn=0, asynchronously and immediately: s1, s2, PWR_EVENT, PWR_IRQ_EN, clk_output_dest, trap_output_dest, irq_inputsrc, pwr_irq, iomem_ready and iomem_rdata all go to 0.
REQ-034 Reset asserted mid-access aborts that access; no ready pulse occurs after reset is released for the aborted access.
REQ-035 Because s2 resets to 0, no power event is generated while the supplies come up after reset.

Verification
REQ-036 Write 0x04 with wdata=0x3 and wstrb=0x1 -> ready pulses one cycle, clk_output_dest=2'b11; a subsequent read returns 0x3.
REQ-037 pwrgood_in=4'hF is held, then bit 2 is dropped -> PWR_STATUS reads 0xB within 2 edges, PWR_EVENT reads 0x4, and pwr_irq stays 0 while PWR_IRQ_EN=0.
REQ-038 Set PWR_IRQ_EN=0x4 with event bit 2 pending -> pwr_irq=1 one cycle later; write 0x4 to 0x10 -> PWR_EVENT reads 0 and pwr_irq drops to 0.
REQ-039 Issue a W1C of bit 0 on the same edge that s2[0] falls -> PWR_EVENT[0] remains 1.
REQ-040 Read offset 0x20 -> ready with rdata=0; access with addr=BASE_ADR+0x100 -> no ready within 8 cycles.
REQ-041 Assert resetn low during a pending write to 0x0C -> irq_inputsrc=0 and no ready pulse after reset is released.
